// File: rtl/serial_cpa_pkg.sv
// Shared types and defaults for the bit-serial carry-propagate adder.
package serial_cpa_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder_bit.sv
// One-bit full adder; the serial adder reuses a single instance every cycle.
module full_adder_bit (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic sum,
  output logic co
);

  assign sum = x ^ y ^ ci;
  assign co  = (x & y) | (x & ci) | (y & ci);

endmodule

// File: rtl/serial_cpa_adder.sv
// Bit-serial adder: one operand bit per cycle, LSB first, result published on DONE entry.
// state | meaning:  IDLE | waiting for start;  RUN | adding bit cnt;  DONE | one-cycle done strobe
module serial_cpa_adder
  import serial_cpa_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [WIDTH-2:0] sum_sh;
  logic [WIDTH-1:0] sum_cat;
  logic c;
  logic fa_sum, fa_co;
  logic load, finish;

  full_adder_bit u_fa (
    .x   (a_sh[0]),
    .y   (b_sh[0]),
    .ci  (c),
    .sum (fa_sum),
    .co  (fa_co)
  );

  // sum_sh keeps the WIDTH-1 most recent sum bits; the current bit completes the word.
  assign sum_cat = {fa_sum, sum_sh};
  assign finish  = (state == RUN) && (cnt == LAST);

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      c      <= 1'b0;
      cnt    <= '0;
      sum_sh <= '0;
    end else if (load) begin
      a_sh <= a;
      b_sh <= b;
      c    <= cin;
      cnt  <= '0;
    end else if (state == RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      c      <= fa_co;
      sum_sh <= sum_cat[WIDTH-1:1];
      if (!finish) cnt <= cnt + CW'(1);
    end
  end

  // At the last bit, c is the carry into the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s    <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
    end else if (finish) begin
      s    <= sum_cat;
      cout <= fa_co;
      ovf  <= c ^ fa_co;
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_cpa_adder.sv
// Self-checking bench: arithmetic reference model compared every cycle plus directed literal cases.
module tb_serial_cpa_adder;
  import serial_cpa_pkg::*;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic cin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic busy, done, cout, ovf;
  logic [W-1:0] s;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  serial_cpa_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .s     (s),
    .cout  (cout),
    .ovf   (ovf)
  );

  // Reference: an accepted operation completes W edges later with plain integer addition.
  bit           m_inflight;
  int           m_rem;
  logic [W-1:0] m_a, m_b, m_s;
  logic         m_c, m_cout, m_ovf, m_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_inflight = 0;
      m_rem      = 0;
      m_a = '0; m_b = '0; m_c = 1'b0;
      m_s = '0; m_cout = 1'b0; m_ovf = 1'b0; m_done = 1'b0;
    end else begin : step
      bit ready;
      logic [W:0] tot;
      ready  = !m_inflight;
      m_done = 1'b0;
      if (m_inflight) begin
        m_rem--;
        if (m_rem == 0) begin
          m_inflight = 0;
          m_done     = 1'b1;
          tot        = {1'b0, m_a} + {1'b0, m_b} + (W+1)'(m_c);
          m_s        = tot[W-1:0];
          m_cout     = tot[W];
          m_ovf      = (m_a[W-1] == m_b[W-1]) && (m_s[W-1] != m_a[W-1]);
        end
      end
      if (ready && start) begin
        m_a = a; m_b = b; m_c = cin;
        m_inflight = 1;
        m_rem      = W;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    #2;
    chk("busy", busy, m_inflight);
    chk("done", done, m_done);
    chk("s", s, m_s);
    chk("cout", cout, m_cout);
    chk("ovf", ovf, m_ovf);
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
    a = ta; b = tb; cin = tc; start = 1'b1;
    tick;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    chk("busy_after_accept", busy, 1'b1);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    do begin
      tick;
      n++;
    end while (!done && n < 20);
    chk(name, n, W);
  endtask

  initial begin
    int nb, nd;
    rst_n = 1'b0;
    repeat (2) tick;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_s", s, 4'b0000);
    chk("rst_cout", cout, 1'b0);
    chk("rst_ovf", ovf, 1'b0);

    // Start issued for the very first edge after reset release.
    rst_n = 1'b1;
    start_op(4'b0101, 4'b0011, 1'b0);
    wait_done("lat_0101_0011");
    chk("s_0101_0011", s, 4'b1000);
    chk("cout_0101_0011", cout, 1'b0);
    chk("ovf_0101_0011", ovf, 1'b1);
    chk("model_0101_0011", m_s, 4'b1000);
    tick;
    chk("done_single", done, 1'b0);
    chk("idle_busy", busy, 1'b0);

    start_op(4'b1111, 4'b0001, 1'b0);
    wait_done("lat_1111_0001");
    chk("s_1111_0001", s, 4'b0000);
    chk("cout_1111_0001", cout, 1'b1);
    chk("ovf_1111_0001", ovf, 1'b0);
    chk("model_cout_1111_0001", m_cout, 1'b1);

    start_op(4'b1111, 4'b1111, 1'b1);
    wait_done("lat_1111_1111_c");
    chk("s_1111_1111_c", s, 4'b1111);
    chk("cout_1111_1111_c", cout, 1'b1);
    chk("ovf_1111_1111_c", ovf, 1'b0);
    tick;

    // Start pulsed mid-RUN must be ignored.
    start_op(4'b0010, 4'b0011, 1'b0);
    nb = 0; nd = 0;
    for (int i = 0; i < 12; i++) begin
      nb += int'(busy);
      nd += int'(done);
      if (i == 2) begin start = 1'b1; a = 4'b0001; b = 4'b0001; end
      if (i == 3) start = 1'b0;
      tick;
    end
    chk("busy_cycles_ignored_start", nb, 4);
    chk("done_pulses_ignored_start", nd, 1);
    chk("s_0010_0011", s, 4'b0101);

    // Reset pulse mid-RUN aborts without a result.
    start_op(4'b0101, 4'b0011, 1'b0);
    tick;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_s", s, 4'b0000);
    tick;
    rst_n = 1'b1;
    nd = 0;
    repeat (8) begin
      nd += int'(done);
      tick;
    end
    chk("abort_no_done", nd, 0);
    chk("abort_s_held", s, 4'b0000);
    start_op(4'b0111, 4'b0001, 1'b0);
    wait_done("lat_0111_0001");
    chk("s_0111_0001", s, 4'b1000);
    chk("ovf_0111_0001", ovf, 1'b1);
    tick;

    // Back-to-back: start held in the DONE cycle.
    start_op(4'b0001, 4'b0010, 1'b0);
    wait_done("lat_first_b2b");
    chk("s_first_b2b", s, 4'b0011);
    a = 4'b0011; b = 4'b0100; cin = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    chk("b2b_no_gap", busy, 1'b1);
    wait_done("lat_second_b2b");
    chk("s_second_b2b", s, 4'b0111);

    repeat (500) begin
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      start = ($urandom_range(0, 2) == 0);
      rst_n = ($urandom_range(0, 99) != 0);
      tick;
    end
    rst_n = 1'b1;
    start = 1'b0;
    repeat (10) tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
